// File: rtl/demux3_reg_if.sv
// Stream bundle for demux3_reg: one tagged input stream and three registered output channels.
// master = producer/consumer side, slave = the demultiplexer.
interface demux3_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [WIDTH-1:0] out0_data;
  logic [WIDTH-1:0] out1_data;
  logic [WIDTH-1:0] out2_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out0_data, out1_data, out2_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out0_data, out1_data, out2_data
  );
endinterface

// File: rtl/demux3_reg.sv
// 1-to-3 registered stream demux, 1-cycle latency, one slot per channel; in_ready low only when the selected slot is full and not draining.
// Illegal select (2'b11) is swallowed and sets sticky err; DEMUX3_ERRCNT_EN adds a saturating err_cnt.
module demux3_reg #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  demux3_reg_if.slave    bus,
  input  logic           err_clr,
  output logic           err
`ifdef DEMUX3_ERRCNT_EN
  ,
  output logic [7:0]     err_cnt
`endif
);

  logic [2:0]            vld_q;
  logic [2:0][WIDTH-1:0] dat_q;
  logic [2:0]            drain;
  logic [2:0]            load;
  logic                  in_rdy;
  logic                  acc;
  logic                  ill_acc;
  logic                  err_q;

  // Ready is a function of the selected slot only, never of in_valid.
  always_comb begin
    drain = vld_q & bus.out_ready;
    case (bus.in_sel)
      2'd0:    in_rdy = !vld_q[0] | bus.out_ready[0];
      2'd1:    in_rdy = !vld_q[1] | bus.out_ready[1];
      2'd2:    in_rdy = !vld_q[2] | bus.out_ready[2];
      default: in_rdy = 1'b1;
    endcase
    acc     = bus.in_valid & in_rdy;
    ill_acc = acc & (bus.in_sel == 2'b11);
    // A shift past bit 2 yields zero, so the illegal select loads nothing.
    load    = {3{acc}} & (3'b001 << bus.in_sel);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (load[k]) begin
          vld_q[k] <= 1'b1;
          dat_q[k] <= bus.in_data;
        end else if (drain[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (ill_acc)
      err_q <= 1'b1;
    else if (err_clr)
      err_q <= 1'b0;
  end

`ifdef DEMUX3_ERRCNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= 8'd0;
    else if (ill_acc)
      cnt_q <= err_clr ? 8'd1 : ((cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1);
    else if (err_clr)
      cnt_q <= 8'd0;
  end

  assign err_cnt = cnt_q;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.out0_data = dat_q[0];
  assign bus.out1_data = dat_q[1];
  assign bus.out2_data = dat_q[2];
  assign err           = err_q;

endmodule

// File: tb/tb_demux3_reg.sv
// Directed bench for demux3_reg: vector table for routing/stall/err, then streaming, backpressure and async reset sequences.
module tb_demux3_reg;

  logic       clk;
  logic       reset_n;
  logic       err_clr;
  logic       err;
`ifdef DEMUX3_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  demux3_reg_if #(.WIDTH(32)) bus ();

  demux3_reg #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .err_clr (err_clr),
    .err     (err)
`ifdef DEMUX3_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] dat;
    logic [2:0]  ordy;
    logic        clr;
    logic        x_rdy;
    logic [2:0]  x_ov;
    logic [31:0] x_d0;
    logic [31:0] x_d1;
    logic [31:0] x_d2;
    logic        x_err;
    logic [7:0]  x_cnt;
  } vec_t;

  vec_t vt [15];

  initial begin
    int sent, rcv, cyc;
    logic [31:0] exp_q [$];
    logic [31:0] stall_dat;
    logic [31:0] exp_w;
    logic stall, rnd;

    //          vld  sel   dat            ordy    clr   rdy   ov      d0             d1             d2             err   cnt
    vt[0]  = '{1'b1, 2'd0, 32'hA5A5_0001, 3'b000, 1'b0, 1'b1, 3'b001, 32'hA5A5_0001, 32'h0,         32'h0,         1'b0, 8'd0};
    vt[1]  = '{1'b1, 2'd1, 32'hA5A5_0002, 3'b000, 1'b0, 1'b1, 3'b011, 32'hA5A5_0001, 32'hA5A5_0002, 32'h0,         1'b0, 8'd0};
    vt[2]  = '{1'b1, 2'd2, 32'hA5A5_0003, 3'b000, 1'b0, 1'b1, 3'b111, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 1'b0, 8'd0};
    vt[3]  = '{1'b0, 2'd1, 32'hA5A5_0004, 3'b000, 1'b0, 1'b0, 3'b111, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 1'b0, 8'd0};
    vt[4]  = '{1'b1, 2'd1, 32'hA5A5_0004, 3'b000, 1'b0, 1'b0, 3'b111, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 1'b0, 8'd0};
    vt[5]  = '{1'b1, 2'd1, 32'hA5A5_0004, 3'b010, 1'b0, 1'b1, 3'b111, 32'hA5A5_0001, 32'hA5A5_0004, 32'hA5A5_0003, 1'b0, 8'd0};
    vt[6]  = '{1'b0, 2'd1, 32'h0,         3'b111, 1'b0, 1'b1, 3'b000, 32'hA5A5_0001, 32'hA5A5_0004, 32'hA5A5_0003, 1'b0, 8'd0};
    vt[7]  = '{1'b1, 2'd3, 32'hDEAD_BEEF, 3'b000, 1'b0, 1'b1, 3'b000, 32'hA5A5_0001, 32'hA5A5_0004, 32'hA5A5_0003, 1'b1, 8'd1};
    vt[8]  = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 1'b1, 3'b000, 32'hA5A5_0001, 32'hA5A5_0004, 32'hA5A5_0003, 1'b0, 8'd0};
    vt[9]  = '{1'b1, 2'd3, 32'h1234_5678, 3'b000, 1'b1, 1'b1, 3'b000, 32'hA5A5_0001, 32'hA5A5_0004, 32'hA5A5_0003, 1'b1, 8'd1};
    vt[10] = '{1'b0, 2'd3, 32'h0,         3'b000, 1'b0, 1'b1, 3'b000, 32'hA5A5_0001, 32'hA5A5_0004, 32'hA5A5_0003, 1'b1, 8'd1};
    vt[11] = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 1'b1, 3'b000, 32'hA5A5_0001, 32'hA5A5_0004, 32'hA5A5_0003, 1'b0, 8'd0};
    vt[12] = '{1'b1, 2'd0, 32'h0000_0011, 3'b000, 1'b0, 1'b1, 3'b001, 32'h0000_0011, 32'hA5A5_0004, 32'hA5A5_0003, 1'b0, 8'd0};
    vt[13] = '{1'b1, 2'd3, 32'h0000_0022, 3'b000, 1'b0, 1'b1, 3'b001, 32'h0000_0011, 32'hA5A5_0004, 32'hA5A5_0003, 1'b1, 8'd1};
    vt[14] = '{1'b0, 2'd0, 32'h0,         3'b001, 1'b1, 1'b1, 3'b000, 32'h0000_0011, 32'hA5A5_0004, 32'hA5A5_0003, 1'b0, 8'd0};

    // Reset state
    reset_n = 1'b0;
    err_clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 32'h0;
    bus.out_ready = 3'b000;
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(3'b000));
    chk("rst_out0", 64'(bus.out0_data), 64'h0);
    chk("rst_out1", 64'(bus.out1_data), 64'h0);
    chk("rst_out2", 64'(bus.out2_data), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
`ifdef DEMUX3_ERRCNT_EN
    chk("rst_err_cnt", 64'(err_cnt), 64'h0);
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_out_valid", 64'(bus.out_valid), 64'(3'b000));
    chk("idle_err", 64'(err), 64'h0);

    // Routing, stall, load-while-drain, illegal select
    for (int i = 0; i < 15; i++) begin
      bus.in_valid  = vt[i].vld;
      bus.in_sel    = vt[i].sel;
      bus.in_data   = vt[i].dat;
      bus.out_ready = vt[i].ordy;
      err_clr       = vt[i].clr;
      #2;
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(vt[i].x_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vt[i].x_ov));
      chk($sformatf("v%0d_out0", i), 64'(bus.out0_data), 64'(vt[i].x_d0));
      chk($sformatf("v%0d_out1", i), 64'(bus.out1_data), 64'(vt[i].x_d1));
      chk($sformatf("v%0d_out2", i), 64'(bus.out2_data), 64'(vt[i].x_d2));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vt[i].x_err));
`ifdef DEMUX3_ERRCNT_EN
      chk($sformatf("v%0d_err_cnt", i), 64'(err_cnt), 64'(vt[i].x_cnt));
`endif
    end
    err_clr = 1'b0;

    // Streaming to ch2 with consumer always ready: one word per cycle
    bus.out_ready = 3'b100;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd2;
      bus.in_data  = 32'hC0DE_0000 + 32'(i);
      #2;
      chk($sformatf("st%0d_in_ready", i), 64'(bus.in_ready), 64'h1);
      @(posedge clk); #1;
      chk($sformatf("st%0d_valid", i), 64'(bus.out_valid[2]), 64'h1);
      chk($sformatf("st%0d_data", i), 64'(bus.out2_data), 64'(32'hC0DE_0000 + 32'(i)));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("st_drained", 64'(bus.out_valid), 64'(3'b000));

    // Random backpressure on ch0, scoreboarded
    sent = 0; rcv = 0; cyc = 0; stall = 1'b0; stall_dat = 32'h0;
    bus.in_sel = 2'd0;
    while (rcv < 100 && cyc < 3000) begin
      bus.in_valid  = (sent < 100);
      bus.in_data   = 32'hB000_0000 + 32'(sent);
      rnd           = 1'($urandom_range(0, 1));
      bus.out_ready = {2'b00, rnd};
      #2;
      if (stall) begin
        chk("bp_hold_valid", 64'(bus.out_valid[0]), 64'h1);
        chk("bp_hold_data", 64'(bus.out0_data), 64'(stall_dat));
      end
      chk("bp_in_ready", 64'(bus.in_ready), 64'(!bus.out_valid[0] | rnd));
      if (bus.out_valid[0] && rnd) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("bp_order", 64'(bus.out0_data), 64'(exp_w));
        rcv++;
      end
      stall     = bus.out_valid[0] & !rnd;
      stall_dat = bus.out0_data;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_received", 64'(rcv), 64'd100);
    bus.in_valid  = 1'b0;
    bus.out_ready = 3'b000;

`ifdef DEMUX3_ERRCNT_EN
    // Counter saturation
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd3;
    repeat (300) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("cnt_saturated", 64'(err_cnt), 64'hFF);
    chk("cnt_err", 64'(err), 64'h1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("cnt_cleared", 64'(err_cnt), 64'h0);
`endif

    // Async reset with all slots full
    bus.out_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'(k);
      bus.in_data  = 32'hFACE_0000 + 32'(k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("ar_full", 64'(bus.out_valid), 64'(3'b111));
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(bus.out_valid), 64'(3'b000));
    chk("ar_out1", 64'(bus.out1_data), 64'h0);
    chk("ar_in_ready", 64'(bus.in_ready), 64'h1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_idle", 64'(bus.out_valid), 64'(3'b000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux3_reg.md
# demux3_reg

Registered 1-to-3 stream demultiplexer: the distribution counterpart of the 3-input selector. Accepts one valid/ready input stream tagged with a 2-bit select and delivers each word to exactly one of three registered output channels, each buffered by a one-entry slot with full throughput. Sits between a single producer (e.g. writeback/result bus) and three independent consumers. Flags illegal selects.

## Interface
- WIDTH, 32, data width of input and all outputs
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  input accepted this cycle when in_valid & in_ready
- in_sel  in  2  destination: 2'b00→ch0, 2'b01→ch1, 2'b10→ch2, 2'b11 illegal
- in_data  in  WIDTH  input word
- out_valid  out  3  bit k: channel k slot holds a word
- out_ready  in  3  bit k: channel k consumer takes word when out_valid[k] & out_ready[k]
- out0_data, out1_data, out2_data  out  WIDTH  channel slot contents
- err  out  1  sticky illegal-select flag
- err_clr  in  1  synchronous clear of err (and counter, if built)

## Operation
- Per channel k: one slot register (valid bit + WIDTH data). outk_data driven directly from slot register; no combinational path in_data→out.
- Accept = in_valid & in_ready.
- in_ready for legal sel=k: !out_valid[k] | out_ready[k] (slot empty or draining this cycle). Depends only on in_sel, out_valid, out_ready; never on in_valid.
- in_ready for sel=2'b11: 1 (word consumed and discarded; never blocks producer).
- Slot k update each cycle: load if accept with sel=k; else clear valid if out_valid[k] & out_ready[k]; else hold. Load while draining: valid stays 1, data replaced (back-to-back, 1 word/cycle).
- Slot data holds stable while out_valid[k] & !out_ready[k].
- Slots for other channels unaffected by a word to channel k; channels drain independently, no ordering across channels, FIFO order within a channel (trivially, depth 1).
- Illegal accept (sel=2'b11, in_valid=1): no slot changes, err set next cycle.
- err_clr and illegal accept same cycle: err ends 1 (set wins).
- err_clr has no effect on slots.

## Timing
- Reset (reset_n low, async): out_valid=3'b000, all outk_data=0, err=0; in_ready then reflects empty slots (1 for all sel).
- Reset mid-operation: buffered words discarded immediately; no output handshake completes while reset_n low.
- Latency: word accepted at edge N appears on outk with out_valid[k]=1 after edge N; earliest consumption in cycle after acceptance.
- Throughput: 1 word/cycle to one channel when its consumer holds out_ready=1; full-stall when slot full and out_ready low.
- out_valid[k] never drops without a handshake except on reset.

## Configuration
- DEMUX3_ERRCNT_EN defined: adds output err_cnt [7:0], counts illegal accepts, saturates at 8'hFF, reset 0, cleared by err_clr (increment wins over clear same cycle → value 1 after clear+increment). err = (err_cnt != 0) semantics preserved as sticky flag.
- Undefined: no err_cnt port; only sticky err.

## Test plan
- Reset: hold reset_n=0 → out_valid=000, data 0, err=0, in_ready=1; release, stays idle with in_valid=0.
- Routing: send 0xA5A5_0001 sel=00, 0xA5A5_0002 sel=01, 0xA5A5_0003 sel=10 with all out_ready=0 → out_valid=111, out0/1/2 carry respective values; fourth word sel=01 → in_ready=0 until out_ready[1] pulses, then out1_data=new word.
- Streaming: 16 words sel=10 with out_ready[2]=1 continuously → one accept per cycle, outputs in order, 1-cycle latency, no bubbles.
- Backpressure: out_ready[0] toggles randomly, 100 words to ch0 → no loss/duplication, data stable while stalled.
- Illegal select: sel=11 word with in_valid=1 → in_ready=1, no out_valid change, err=1 next cycle; err_clr=1 → err=0; clr+illegal same cycle → err=1 (with DEMUX3_ERRCNT_EN: 300 illegal words → err_cnt=0xFF).
- Async reset mid-stream: assert reset_n low between edges with slots full → out_valid=000 immediately.
